// File: rtl/lsu_mem_arbiter.sv
// lsu_mem_arbiter
//   Multiplexes LDR/STR requests from NUM_CONSUMERS LSU ports onto
//   NUM_CHANNELS data-memory channels. Consumers are picked round-robin.
//   Each channel runs its own request/relay FSM. A consumer is owned by
//   at most one channel at a time.
//
// Ports
//   clk, reset                        clock, async active-low reset
//   consumer_read_valid/address       per-LSU read requests (packed slices)
//   consumer_read_ready/data          per-LSU read completion, registered
//   consumer_write_valid/address/data per-LSU write requests
//   consumer_write_ready              per-LSU write completion, registered
//   mem_read_valid/address            per-channel read request, registered
//   mem_read_ready/data               per-channel read acknowledge + data
//   mem_write_valid/address/data      per-channel write request, registered
//   mem_write_ready                   per-channel write acknowledge
//
// state          | meaning
// ---------------+-------------------------------------------------------
// IDLE           | searching for an unclaimed requesting consumer
// READ_WAITING   | mem_read_valid high, waiting for mem_read_ready
// WRITE_WAITING  | mem_write_valid high, waiting for mem_write_ready
// READ_RELAYING  | consumer_read_ready high until consumer drops read_valid
// WRITE_RELAYING | consumer_write_ready high until consumer drops write_valid
module lsu_mem_arbiter #(
  parameter int NUM_CONSUMERS = 4,
  parameter int NUM_CHANNELS  = 1,
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
  input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
  output logic [NUM_CHANNELS-1:0]            mem_read_valid,
  output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_read_address,
  input  logic [NUM_CHANNELS-1:0]            mem_read_ready,
  input  logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_read_data,
  output logic [NUM_CHANNELS-1:0]            mem_write_valid,
  output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_write_address,
  output logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_write_data,
  input  logic [NUM_CHANNELS-1:0]            mem_write_ready
);

  localparam int CW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

  typedef enum logic [2:0] {
    IDLE, READ_WAITING, WRITE_WAITING, READ_RELAYING, WRITE_RELAYING
  } state_e;

  state_e                   state_q [NUM_CHANNELS];
  state_e                   state_d [NUM_CHANNELS];
  // Owning consumer per channel, kept one-hot so every select is a plain mask
  logic [NUM_CONSUMERS-1:0] cons_q  [NUM_CHANNELS];
  logic [NUM_CONSUMERS-1:0] cons_d  [NUM_CHANNELS];
  logic [NUM_CONSUMERS-1:0] claimed_q, claimed_d;
  logic [CW-1:0]            rr_q, rr_d;

  logic [NUM_CHANNELS-1:0]  gnt_rd, gnt_wr, done_rd, done_wr, rel;
  logic [NUM_CONSUMERS-1:0] taken;
  logic                     found, any_gnt;
  int                       hi;

  logic [NUM_CONSUMERS-1:0]           c_rrdy_q, c_rrdy_d, c_wrdy_q, c_wrdy_d;
  logic [NUM_CONSUMERS*DATA_BITS-1:0] c_rdata_q, c_rdata_d;
  logic [NUM_CHANNELS-1:0]            m_rvalid_q, m_rvalid_d, m_wvalid_q, m_wvalid_d;
  logic [NUM_CHANNELS*ADDR_BITS-1:0]  m_raddr_q, m_raddr_d, m_waddr_q, m_waddr_d;
  logic [NUM_CHANNELS*DATA_BITS-1:0]  m_wdata_q, m_wdata_d;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        state_q[c] <= IDLE;
        cons_q[c]  <= '0;
      end
      claimed_q  <= '0;
      rr_q       <= '0;
      c_rrdy_q   <= '0;
      c_wrdy_q   <= '0;
      c_rdata_q  <= '0;
      m_rvalid_q <= '0;
      m_wvalid_q <= '0;
      m_raddr_q  <= '0;
      m_waddr_q  <= '0;
      m_wdata_q  <= '0;
    end else begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        state_q[c] <= state_d[c];
        cons_q[c]  <= cons_d[c];
      end
      claimed_q  <= claimed_d;
      rr_q       <= rr_d;
      c_rrdy_q   <= c_rrdy_d;
      c_wrdy_q   <= c_wrdy_d;
      c_rdata_q  <= c_rdata_d;
      m_rvalid_q <= m_rvalid_d;
      m_wvalid_q <= m_wvalid_d;
      m_raddr_q  <= m_raddr_d;
      m_waddr_q  <= m_waddr_d;
      m_wdata_q  <= m_wdata_d;
    end
  end

  // Next state: channels resolve in ascending order; 'taken' holds this
  // cycle's grants so a later channel cannot pick the same consumer.
  always_comb begin
    taken     = '0;
    any_gnt   = 1'b0;
    hi        = 0;
    found     = 1'b0;
    claimed_d = claimed_q;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      state_d[c] = state_q[c];
      cons_d[c]  = cons_q[c];
      gnt_rd[c]  = 1'b0;
      gnt_wr[c]  = 1'b0;
      done_rd[c] = 1'b0;
      done_wr[c] = 1'b0;
      rel[c]     = 1'b0;
      found      = 1'b0;
      case (state_q[c])
        IDLE: begin
          // Pass 0 scans rr..N-1, pass 1 wraps to 0..rr-1
          for (int p = 0; p < 2; p++) begin
            for (int k = 0; k < NUM_CONSUMERS; k++) begin
              if (((p == 0) == (k >= int'(rr_q))) && !found && !claimed_q[k] &&
                  !taken[k] && (consumer_read_valid[k] || consumer_write_valid[k])) begin
                found      = 1'b1;
                taken[k]   = 1'b1;
                cons_d[c]  = '0;
                cons_d[c][k] = 1'b1;
                any_gnt    = 1'b1;
                if (k > hi) hi = k;
                if (consumer_read_valid[k]) begin
                  state_d[c] = READ_WAITING;
                  gnt_rd[c]  = 1'b1;
                end else begin
                  state_d[c] = WRITE_WAITING;
                  gnt_wr[c]  = 1'b1;
                end
              end
            end
          end
        end
        READ_WAITING: if (mem_read_ready[c]) begin
          state_d[c] = READ_RELAYING;
          done_rd[c] = 1'b1;
        end
        WRITE_WAITING: if (mem_write_ready[c]) begin
          state_d[c] = WRITE_RELAYING;
          done_wr[c] = 1'b1;
        end
        READ_RELAYING: if (!(|(consumer_read_valid & cons_q[c]))) begin
          state_d[c] = IDLE;
          rel[c]     = 1'b1;
          claimed_d  = claimed_d & ~cons_q[c];
        end
        WRITE_RELAYING: if (!(|(consumer_write_valid & cons_q[c]))) begin
          state_d[c] = IDLE;
          rel[c]     = 1'b1;
          claimed_d  = claimed_d & ~cons_q[c];
        end
        default: state_d[c] = IDLE;
      endcase
    end
    claimed_d = claimed_d | taken;
    rr_d = any_gnt ? CW'((hi + 1) % NUM_CONSUMERS) : rr_q;
  end

  // Output next values; address/data are latched only at grant
  always_comb begin
    c_rrdy_d   = c_rrdy_q;
    c_wrdy_d   = c_wrdy_q;
    c_rdata_d  = c_rdata_q;
    m_rvalid_d = m_rvalid_q;
    m_wvalid_d = m_wvalid_q;
    m_raddr_d  = m_raddr_q;
    m_waddr_d  = m_waddr_q;
    m_wdata_d  = m_wdata_q;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (gnt_rd[c]) m_rvalid_d[c] = 1'b1;
      if (gnt_wr[c]) m_wvalid_d[c] = 1'b1;
      if (done_rd[c]) m_rvalid_d[c] = 1'b0;
      if (done_wr[c]) m_wvalid_d[c] = 1'b0;
      if (rel[c]) begin
        c_rrdy_d = c_rrdy_d & ~cons_q[c];
        c_wrdy_d = c_wrdy_d & ~cons_q[c];
      end
      for (int k = 0; k < NUM_CONSUMERS; k++) begin
        if (gnt_rd[c] && cons_d[c][k])
          m_raddr_d[c*ADDR_BITS +: ADDR_BITS] = consumer_read_address[k*ADDR_BITS +: ADDR_BITS];
        if (gnt_wr[c] && cons_d[c][k]) begin
          m_waddr_d[c*ADDR_BITS +: ADDR_BITS] = consumer_write_address[k*ADDR_BITS +: ADDR_BITS];
          m_wdata_d[c*DATA_BITS +: DATA_BITS] = consumer_write_data[k*DATA_BITS +: DATA_BITS];
        end
        if (done_rd[c] && cons_q[c][k]) begin
          c_rrdy_d[k] = 1'b1;
          c_rdata_d[k*DATA_BITS +: DATA_BITS] = mem_read_data[c*DATA_BITS +: DATA_BITS];
        end
        if (done_wr[c] && cons_q[c][k]) c_wrdy_d[k] = 1'b1;
      end
    end
  end

  assign consumer_read_ready  = c_rrdy_q;
  assign consumer_read_data   = c_rdata_q;
  assign consumer_write_ready = c_wrdy_q;
  assign mem_read_valid       = m_rvalid_q;
  assign mem_read_address     = m_raddr_q;
  assign mem_write_valid      = m_wvalid_q;
  assign mem_write_address    = m_waddr_q;
  assign mem_write_data       = m_wdata_q;

endmodule

// File: tb/tb_lsu_mem_arbiter.sv
// tb_lsu_mem_arbiter
//   Directed checks on a single-channel arbiter (dut_a) and a two-channel
//   arbiter (dut_b), then randomized traffic on dut_b checked against a
//   memory image and per-consumer expected results.
`timescale 1ns/1ps
module tb_lsu_mem_arbiter;
  localparam int NC = 4;
  localparam int A  = 8;
  localparam int D  = 8;

`define CHK(TAG, OBS, EXP) \
  begin \
    n_cmp++; \
    assert ((OBS) === (EXP)) else begin \
      n_err++; \
      $error("FAIL %s: observed %0h, expected %0h", TAG, OBS, EXP); \
    end \
  end

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // dut_a: one channel
  logic [NC-1:0]   a_c_rv, a_c_rr, a_c_wv, a_c_wr;
  logic [NC*A-1:0] a_c_ra, a_c_wa;
  logic [NC*D-1:0] a_c_rd, a_c_wd;
  logic            a_m_rv, a_m_rr, a_m_wv, a_m_wr;
  logic [A-1:0]    a_m_ra, a_m_wa;
  logic [D-1:0]    a_m_rd, a_m_wd;

  // dut_b: two channels
  logic [NC-1:0]   b_c_rv, b_c_rr, b_c_wv, b_c_wr;
  logic [NC*A-1:0] b_c_ra, b_c_wa;
  logic [NC*D-1:0] b_c_rd, b_c_wd;
  logic [1:0]      b_m_rv, b_m_rr, b_m_wv, b_m_wr;
  logic [2*A-1:0]  b_m_ra, b_m_wa;
  logic [2*D-1:0]  b_m_rd, b_m_wd;

  lsu_mem_arbiter #(.NUM_CONSUMERS(NC), .NUM_CHANNELS(1), .ADDR_BITS(A), .DATA_BITS(D)) dut_a (
    .clk(clk), .reset(reset),
    .consumer_read_valid(a_c_rv), .consumer_read_address(a_c_ra),
    .consumer_read_ready(a_c_rr), .consumer_read_data(a_c_rd),
    .consumer_write_valid(a_c_wv), .consumer_write_address(a_c_wa),
    .consumer_write_data(a_c_wd), .consumer_write_ready(a_c_wr),
    .mem_read_valid(a_m_rv), .mem_read_address(a_m_ra),
    .mem_read_ready(a_m_rr), .mem_read_data(a_m_rd),
    .mem_write_valid(a_m_wv), .mem_write_address(a_m_wa),
    .mem_write_data(a_m_wd), .mem_write_ready(a_m_wr));

  lsu_mem_arbiter #(.NUM_CONSUMERS(NC), .NUM_CHANNELS(2), .ADDR_BITS(A), .DATA_BITS(D)) dut_b (
    .clk(clk), .reset(reset),
    .consumer_read_valid(b_c_rv), .consumer_read_address(b_c_ra),
    .consumer_read_ready(b_c_rr), .consumer_read_data(b_c_rd),
    .consumer_write_valid(b_c_wv), .consumer_write_address(b_c_wa),
    .consumer_write_data(b_c_wd), .consumer_write_ready(b_c_wr),
    .mem_read_valid(b_m_rv), .mem_read_address(b_m_ra),
    .mem_read_ready(b_m_rr), .mem_read_data(b_m_rd),
    .mem_write_valid(b_m_wv), .mem_write_address(b_m_wa),
    .mem_write_data(b_m_wd), .mem_write_ready(b_m_wr));

  // Reference state for the randomized phase
  logic [7:0] mem     [256];
  logic [7:0] ref_mem [256];
  int         pend_op [NC];   // 0 idle, 1 read, 2 write
  logic [7:0] pend_addr [NC];
  logic [7:0] pend_data [NC];
  int         age [NC];
  int         max_age, done_cnt, nbad, npend;
  logic       ok;
  int         order[$];
  int         exp_order[5] = '{0, 1, 2, 3, 1};
  logic [7:0] addr_v;

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    a_c_rv = '0; a_c_wv = '0; a_c_ra = '0; a_c_wa = '0; a_c_wd = '0;
    a_m_rr = 1'b0; a_m_wr = 1'b0; a_m_rd = '0;
    b_c_rv = '0; b_c_wv = '0; b_c_ra = '0; b_c_wa = '0; b_c_wd = '0;
    b_m_rr = '0; b_m_wr = '0; b_m_rd = '0;
    reset = 1'b1;
    #1 reset = 1'b0;
    #1;
    `CHK("reset_a_mem_valid", {a_m_rv, a_m_wv}, 2'b00)
    `CHK("reset_a_cons_ready", {a_c_rr, a_c_wr}, 8'h00)
    `CHK("reset_b_mem_valid", {b_m_rv, b_m_wv}, 4'h0)

    // Single read from consumer 2, address changed after grant
    @(negedge clk);
    reset = 1'b1;
    a_c_ra[2*A +: A] = 8'h3C;
    a_c_rv[2] = 1'b1;
    tick();
    `CHK("rd_mem_valid", a_m_rv, 1'b1)
    `CHK("rd_mem_addr", a_m_ra, 8'h3C)
    `CHK("rd_cons_ready_early", a_c_rr, 4'h0)
    a_c_ra[2*A +: A] = 8'hFF;
    tick();
    `CHK("rd_addr_held_after_change", a_m_ra, 8'h3C)
    `CHK("rd_mem_valid_waiting", a_m_rv, 1'b1)
    a_m_rd = 8'hA5; a_m_rr = 1'b1;
    tick();
    a_m_rr = 1'b0;
    `CHK("rd_cons_ready", a_c_rr, 4'b0100)
    `CHK("rd_cons_data", a_c_rd[2*D +: D], 8'hA5)
    `CHK("rd_mem_valid_dropped", a_m_rv, 1'b0)
    tick();
    `CHK("rd_ready_held", a_c_rr, 4'b0100)
    a_c_rv[2] = 1'b0;
    tick();
    `CHK("rd_ready_dropped", a_c_rr, 4'h0)
    `CHK("rd_data_retained", a_c_rd[2*D +: D], 8'hA5)

    // Single write from consumer 0, memory acknowledges three cycles later
    a_c_wa[0 +: A] = 8'h10; a_c_wd[0 +: D] = 8'h7E; a_c_wv[0] = 1'b1;
    tick();
    `CHK("wr_mem_valid", a_m_wv, 1'b1)
    `CHK("wr_mem_addr", a_m_wa, 8'h10)
    `CHK("wr_mem_data", a_m_wd, 8'h7E)
    a_c_wa[0 +: A] = 8'h55; a_c_wd[0 +: D] = 8'h33;
    for (int n = 0; n < 2; n++) begin
      tick();
      `CHK("wr_stable_valid", a_m_wv, 1'b1)
      `CHK("wr_stable_addr", a_m_wa, 8'h10)
      `CHK("wr_stable_data", a_m_wd, 8'h7E)
      `CHK("wr_no_early_ready", a_c_wr, 4'h0)
    end
    a_m_wr = 1'b1;
    tick();
    a_m_wr = 1'b0;
    `CHK("wr_cons_ready", a_c_wr, 4'b0001)
    `CHK("wr_mem_valid_dropped", a_m_wv, 1'b0)
    a_c_wv[0] = 1'b0;
    tick();
    `CHK("wr_ready_dropped", a_c_wr, 4'h0)

    // Asynchronous reset while channel waits on a read
    a_c_ra[3*A +: A] = 8'h77; a_c_rv[3] = 1'b1;
    tick();
    `CHK("arst_waiting", a_m_rv, 1'b1)
    for (int i = 0; i < NC; i++) a_c_ra[i*A +: A] = 8'h40 + 8'(i);
    a_c_rv = 4'hF;
    #2 reset = 1'b0;
    #1;
    `CHK("arst_mem_valid", a_m_rv, 1'b0)
    `CHK("arst_mem_addr", a_m_ra, 8'h00)
    `CHK("arst_cons_ready", {a_c_rr, a_c_wr}, 8'h00)
    @(negedge clk);
    reset = 1'b1;

    // Round-robin with zero-wait memory; consumer 1 re-requests during 2
    a_m_rr = 1'b1;
    for (int cyc = 0; cyc < 80 && order.size() < 5; cyc++) begin
      a_m_rd = a_m_ra ^ 8'hFF;
      tick();
      for (int i = 0; i < NC; i++) begin
        if (a_c_rr[i] && a_c_rv[i]) begin
          order.push_back(i);
          `CHK("rr_data", a_c_rd[i*D +: D], (8'h40 + 8'(i)) ^ 8'hFF)
          a_c_rv[i] = 1'b0;
          if (i == 2) a_c_rv[1] = 1'b1;
        end
      end
    end
    `CHK("rr_count", order.size(), 5)
    for (int j = 0; j < 5; j++)
      `CHK("rr_order", (j < order.size()) ? order[j] : -1, exp_order[j])

    // Read wins when a consumer raises both
    tick(); tick();
    a_c_ra[2*A +: A] = 8'h21; a_c_wa[2*A +: A] = 8'h22; a_c_wd[2*D +: D] = 8'h99;
    a_c_rv[2] = 1'b1; a_c_wv[2] = 1'b1;
    tick();
    `CHK("prec_read_valid", a_m_rv, 1'b1)
    `CHK("prec_write_valid", a_m_wv, 1'b0)
    a_c_rv[2] = 1'b0; a_c_wv[2] = 1'b0;
    tick(); tick(); tick();
    a_m_rr = 1'b0;

    // Two channels: consumers 1 and 3 at once
    b_c_ra[1*A +: A] = 8'h11; b_c_ra[3*A +: A] = 8'h33;
    b_c_rv[1] = 1'b1; b_c_rv[3] = 1'b1;
    tick();
    `CHK("two_ch_valid", b_m_rv, 2'b11)
    `CHK("two_ch0_addr", b_m_ra[0 +: A], 8'h11)
    `CHK("two_ch1_addr", b_m_ra[A +: A], 8'h33)
    b_m_rd = {8'hB3, 8'hB1}; b_m_rr = 2'b11;
    tick();
    b_m_rr = 2'b00;
    `CHK("two_ch_ready", b_c_rr, 4'b1010)
    `CHK("two_ch_data1", b_c_rd[1*D +: D], 8'hB1)
    `CHK("two_ch_data3", b_c_rd[3*D +: D], 8'hB3)
    b_c_rv = '0;
    tick();
    // pointer should be back at 0: channel 0 must take consumer 0 over 2
    b_c_ra[0 +: A] = 8'h20; b_c_ra[2*A +: A] = 8'h22;
    b_c_rv[0] = 1'b1; b_c_rv[2] = 1'b1;
    tick();
    `CHK("two_ch_rr_ch0", b_m_ra[0 +: A], 8'h20)
    `CHK("two_ch_rr_ch1", b_m_ra[A +: A], 8'h22)
    b_m_rr = 2'b11;
    tick();
    b_m_rr = 2'b00;
    b_c_rv = '0;
    tick(); tick();

    // Randomized traffic on dut_b; each consumer owns its own address quarter
    for (int a = 0; a < 256; a++) begin
      mem[a] = 8'($urandom);
      ref_mem[a] = mem[a];
    end
    for (int i = 0; i < NC; i++) begin
      pend_op[i] = 0; age[i] = 0;
    end
    max_age = 0; done_cnt = 0;
    for (int cyc = 0; cyc < 900; cyc++) begin
      for (int c = 0; c < 2; c++) begin
        if (b_m_rr[c]) b_m_rr[c] = 1'b0;
        else if (b_m_rv[c] && $urandom_range(0, 1) == 1) begin
          addr_v = b_m_ra[c*A +: A];
          ok = 1'b0;
          for (int i = 0; i < NC; i++) if (pend_op[i] == 1 && pend_addr[i] == addr_v) ok = 1'b1;
          `CHK("rnd_read_addr_known", ok, 1'b1)
          b_m_rd[c*D +: D] = mem[addr_v];
          b_m_rr[c] = 1'b1;
        end
        if (b_m_wr[c]) b_m_wr[c] = 1'b0;
        else if (b_m_wv[c] && $urandom_range(0, 1) == 1) begin
          addr_v = b_m_wa[c*A +: A];
          ok = 1'b0;
          for (int i = 0; i < NC; i++)
            if (pend_op[i] == 2 && pend_addr[i] == addr_v && pend_data[i] == b_m_wd[c*D +: D]) ok = 1'b1;
          `CHK("rnd_write_req_known", ok, 1'b1)
          mem[addr_v] = b_m_wd[c*D +: D];
          b_m_wr[c] = 1'b1;
        end
      end
      for (int i = 0; i < NC; i++) begin
        if (pend_op[i] == 1 && b_c_rr[i]) begin
          `CHK("rnd_read_data", b_c_rd[i*D +: D], ref_mem[pend_addr[i]])
          b_c_rv[i] = 1'b0; pend_op[i] = 0; done_cnt++;
        end else if (pend_op[i] == 2 && b_c_wr[i]) begin
          ref_mem[pend_addr[i]] = pend_data[i];
          b_c_wv[i] = 1'b0; pend_op[i] = 0; done_cnt++;
        end else if (pend_op[i] != 0) begin
          age[i]++;
          if (age[i] > max_age) max_age = age[i];
        end else if (cyc < 800 && !b_c_rr[i] && !b_c_wr[i] && $urandom_range(0, 2) == 0) begin
          pend_addr[i] = {i[1:0], 6'($urandom_range(0, 7))};
          age[i] = 0;
          if ($urandom_range(0, 1) == 1) begin
            pend_op[i] = 1;
            b_c_ra[i*A +: A] = pend_addr[i];
            b_c_rv[i] = 1'b1;
          end else begin
            pend_op[i] = 2;
            pend_data[i] = 8'($urandom);
            b_c_wa[i*A +: A] = pend_addr[i];
            b_c_wd[i*D +: D] = pend_data[i];
            b_c_wv[i] = 1'b1;
          end
        end
      end
      tick();
    end
    npend = 0;
    for (int i = 0; i < NC; i++) if (pend_op[i] != 0) npend++;
    nbad = 0;
    for (int a = 0; a < 256; a++) if (mem[a] !== ref_mem[a]) nbad++;
    `CHK("rnd_all_drained", npend, 0)
    `CHK("rnd_wait_bounded", max_age <= 60, 1'b1)
    `CHK("rnd_progress", done_cnt > 50, 1'b1)
    `CHK("rnd_mem_image_bad_entries", nbad, 0)

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
